// File: rtl/button_event_decoder.sv
// Turns the debounced button level into single-cycle UI events (press, release,
// click, double-click, long-press, auto-repeat) plus a registered level copy.
module button_event_decoder #(
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000,
    parameter int DOUBLE_GAP_CYCLES = 15_000_000,
    parameter int CNT_W             = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    input  logic enable,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic double_click_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_btn_q;
    logic             w_rise;
    logic             w_fall;
    logic             w_press;
    logic             w_release;
    logic             w_click;
    logic             w_double;
    logic             w_long;
    logic             w_repeat;
    logic             r_press;
    logic             r_release;
    logic             r_click;
    logic             r_double;
    logic             r_long;
    logic             r_repeat;

    assign w_rise = btn_level & ~r_btn_q;
    assign w_fall = ~btn_level & r_btn_q;

    // Next-state and event decode; a fall beats a hold threshold, a rise beats the gap timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_click     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_rise) begin
                        w_press     = 1'b1;
                        w_state_nxt = ST_PRESSED;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        w_release   = 1'b1;
                        w_state_nxt = ST_WAIT_SECOND;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == LONG_LAST) begin
                        w_long      = 1'b1;
                        w_state_nxt = ST_LONG_HELD;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = ST_PRESSED;
                    end
                end
                ST_LONG_HELD: begin
                    if (w_fall) begin
                        w_release   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == REPEAT_LAST) begin
                        w_repeat  = 1'b1;
                        w_cnt_nxt = CNT_ZERO;
                    end else begin
                        w_state_nxt = ST_LONG_HELD;
                    end
                end
                ST_WAIT_SECOND: begin
                    if (w_rise) begin
                        w_press     = 1'b1;
                        w_state_nxt = ST_SECOND_PRESSED;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == GAP_LAST) begin
                        w_click     = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = ST_WAIT_SECOND;
                    end
                end
                ST_SECOND_PRESSED: begin
                    if (w_fall) begin
                        w_release   = 1'b1;
                        w_double    = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == LONG_LAST) begin
                        w_long      = 1'b1;
                        w_state_nxt = ST_LONG_HELD;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = ST_SECOND_PRESSED;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter, level copy and registered event outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_btn_q   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_btn_q   <= btn_level;
            r_press   <= w_press;
            r_release <= w_release;
            r_click   <= w_click;
            r_double  <= w_double;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
        end
    end

    assign press_pulse        = r_press;
    assign release_pulse      = r_release;
    assign click_pulse        = r_click;
    assign double_click_pulse = r_double;
    assign long_press_pulse   = r_long;
    assign repeat_pulse       = r_repeat;
    assign held               = r_btn_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: stimulus queues the expected event
// (cycle, pulse vector); a negedge monitor pops and compares each observed event.
module tb_button_event_decoder;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int GAP  = 6;

    localparam logic [5:0] EV_PRESS = 6'b100000;
    localparam logic [5:0] EV_REL   = 6'b010000;
    localparam logic [5:0] EV_CLICK = 6'b001000;
    localparam logic [5:0] EV_DBL   = 6'b000100;
    localparam logic [5:0] EV_LONG  = 6'b000010;
    localparam logic [5:0] EV_REP   = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] ev;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic btn_level;
    logic enable;
    logic press_pulse, release_pulse, click_pulse, double_click_pulse;
    logic long_press_pulse, repeat_pulse, held;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t0;
    logic btn_prev;

    button_event_decoder #(
        .LONG_PRESS_CYCLES(LONG),
        .REPEAT_CYCLES    (REP),
        .DOUBLE_GAP_CYCLES(GAP),
        .CNT_W            (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .btn_level         (btn_level),
        .enable            (enable),
        .press_pulse       (press_pulse),
        .release_pulse     (release_pulse),
        .click_pulse       (click_pulse),
        .double_click_pulse(double_click_pulse),
        .long_press_pulse  (long_press_pulse),
        .repeat_pulse      (repeat_pulse),
        .held              (held)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Expected value of held: previous sampled level, cleared by reset
    always @(posedge clk or negedge reset) begin
        if (!reset) btn_prev <= 1'b0;
        else        btn_prev <= btn_level;
    end

    // Monitor: checks held every cycle and pops one expectation per observed event
    initial begin
        exp_t       e;
        logic [5:0] ev;
        forever begin
            @(negedge clk);
            ev = {press_pulse, release_pulse, click_pulse, double_click_pulse,
                  long_press_pulse, repeat_pulse};
            total++;
            if (held !== btn_prev) begin
                bad++;
                $display("FAIL held cyc=%0d got=%b want=%b", cyc, held, btn_prev);
            end
            if (ev != 6'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, ev);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.ev !== ev) begin
                        bad++;
                        $display("FAIL event got cyc=%0d ev=%b want cyc=%0d ev=%b",
                                 cyc, ev, e.cyc, e.ev);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input int base, input int s, input logic [5:0] ev);
        exp_t e;
        e.cyc = base + 1 + s;
        e.ev  = ev;
        sb.push_back(e);
    endtask

    task automatic hold(input logic b, input logic en, input int n);
        for (int i = 0; i < n; i++) begin
            btn_level = b;
            enable    = en;
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input string name);
        logic [6:0] got;
        got = {press_pulse, release_pulse, click_pulse, double_click_pulse,
               long_press_pulse, repeat_pulse, held};
        total++;
        if (got !== 7'b0) begin
            bad++;
            $display("FAIL %s got=%b want=0000000", name, got);
        end
    endtask

    task automatic release_and_click;
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS);
        expect_ev(t0, 3, EV_REL);
        expect_ev(t0, 9, EV_CLICK);
        #2 reset = 1'b1;
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b1, 10);
    endtask

    initial begin
        reset     = 1'b1;
        btn_level = 1'b0;
        enable    = 1'b1;
        #1 reset  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_state");
        #2 reset = 1'b1;
        @(negedge clk);
        hold(1'b0, 1'b1, 2);

        // T1 short click
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 3, EV_REL); expect_ev(t0, 9, EV_CLICK);
        hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 10);

        // T2 double click
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 3, EV_REL);
        expect_ev(t0, 5, EV_PRESS); expect_ev(t0, 8, EV_REL | EV_DBL);
        hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 2); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 10);

        // T3 long press with three repeats, no click after release
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 8, EV_LONG);
        expect_ev(t0, 12, EV_REP); expect_ev(t0, 16, EV_REP); expect_ev(t0, 20, EV_REP);
        expect_ev(t0, 21, EV_REL);
        hold(1'b1, 1'b1, 21); hold(1'b0, 1'b1, 10);

        // T4 threshold: 7 and 8 samples stay short (fall wins at 8), 9 goes long
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 7, EV_REL); expect_ev(t0, 13, EV_CLICK);
        hold(1'b1, 1'b1, 7); hold(1'b0, 1'b1, 10);
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 8, EV_REL); expect_ev(t0, 14, EV_CLICK);
        hold(1'b1, 1'b1, 8); hold(1'b0, 1'b1, 10);
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 8, EV_LONG); expect_ev(t0, 9, EV_REL);
        hold(1'b1, 1'b1, 9); hold(1'b0, 1'b1, 10);

        // T5 enable dropped mid-hold, raised while still held, then a fresh click
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 16, EV_PRESS);
        expect_ev(t0, 19, EV_REL); expect_ev(t0, 25, EV_CLICK);
        hold(1'b1, 1'b1, 5); hold(1'b1, 1'b0, 5); hold(1'b1, 1'b1, 4);
        hold(1'b0, 1'b1, 2); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 12);

        // T6a reset while PRESSED, released with the button high
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS);
        hold(1'b1, 1'b1, 4);
        #2 reset = 1'b0;
        #1 check_zero("reset_in_pressed");
        @(negedge clk);
        @(negedge clk);
        release_and_click();

        // T6b reset while LONG_HELD, asserted while long_press_pulse is high
        t0 = cyc;
        expect_ev(t0, 0, EV_PRESS); expect_ev(t0, 8, EV_LONG);
        hold(1'b1, 1'b1, 9);
        #2 reset = 1'b0;
        #1 check_zero("reset_in_long_held");
        @(negedge clk);
        @(negedge clk);
        release_and_click();

        hold(1'b0, 1'b1, 5);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_events got=%0d_pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
